uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver; consumes the serial line produced by uart_tx (loopback or external pin).
//  Oversamples rx using the s_tick strobe from uart_sampling_tick (SAMPLE ticks per bit).
//  Validates the start bit, shifts in DATA_SIZE bits LSB-first and checks the stop bit.
//  Hands each received word to the downstream SEC-DED decoder with a 1-clk done pulse.
// PARAMETERS
//  DATA_SIZE   8                      data bits per frame
//  SAMPLE      16                     s_tick pulses per bit period
//  STOP_TICKS  16                     s_tick pulses in the stop bit (16 = 1 stop bit)
//  S_CNT_SIZE  $clog2(STOP_TICKS)     tick counter width; sized for STOP_TICKS >= SAMPLE
//  BIT_COUNT_SIZE $clog2(DATA_SIZE+1) bit counter width
// PORTS
//  clk           in   1          system clock (50 MHz nominal)
//  reset_n       in   1          asynchronous, active-low reset
//  s_tick        in   1          oversampling strobe, 1 clk wide, from uart_sampling_tick
//  rx            in   1          serial input; idle high; asynchronous to clk
//  data_out      out  DATA_SIZE  last received word; held until the next frame completes
//  rx_done_tick  out  1          1-clk pulse; data_out and frame_err are valid this cycle
//  frame_err     out  1          1 = stop bit sampled low on the last frame
//  rx_busy       out  1          1 while state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; s_cnt=0; n=0; shreg=0; data_out=0;
//    rx_done_tick=0; frame_err=0; synchronizer flops=1.
//  - rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s. A line edge
//    reaches the FSM 2 clk later.
//  - Counters advance only in clk cycles with s_tick=1. No other state changes occur
//    between ticks, except the IDLE->START transition.
//  - IDLE: rx_s==0 in any clk (tick not required) -> START, s_cnt=0.
//  - START: on tick with s_cnt==SAMPLE/2-1, check rx_s:
//      rx_s==0 -> DATA, s_cnt=0, n=0.
//      rx_s==1 -> false start; return to IDLE with no outputs changed.
//    Otherwise, on tick: s_cnt++.
//  - DATA: on tick with s_cnt==SAMPLE-1: shreg={rx_s, shreg[DATA_SIZE-1:1]}, s_cnt=0;
//      n==DATA_SIZE-1 -> STOP; otherwise n++.
//    Otherwise, on tick: s_cnt++.
//    Result: bit mid-points are sampled and the first data bit lands in shreg[0].
//  - STOP: on tick with s_cnt==STOP_TICKS-1, in the same clk:
//      data_out<=shreg; frame_err<=~rx_s; rx_done_tick<=1; state -> IDLE.
//    The done pulse is raised on framing errors too; the consumer uses frame_err to
//    discard the word.
//  - rx_done_tick is registered and is 1 for exactly one clk per completed frame.
//  - frame_err holds its value until the next done pulse.
//  - Back-to-back frames: a start bit that falls right after the stop sample is accepted
//    immediately from IDLE. No idle gap is required.
//  - rx held low forever (break): each cycle produces a frame with data=0 and frame_err=1,
//    then restarts. No lock-up.
//  - Reset mid-frame: frame aborted, no done pulse, all outputs return to reset values.
//  - Latency: rx_done_tick rises at the tick ending the stop-bit sample, about
//    (SAMPLE/2 + DATA_SIZE*SAMPLE + STOP_TICKS) ticks + 3 clk after the start edge on rx.
// TESTING (50 MHz, 115200 baud, SAMPLE=16 -> 27 clk/tick, 432 clk/bit)
//  1. Drive frame 0xCB (line: 0,1,1,0,1,0,0,1,1,1) -> one rx_done_tick, data_out=8'hCB,
//     frame_err=0, rx_busy low afterwards.
//  2. rx low for 4 ticks then high (glitch) -> no rx_done_tick, rx_busy falls within
//     SAMPLE/2 ticks, data_out unchanged.
//  3. Frame 0x55 with stop bit driven 0 -> rx_done_tick, data_out=8'h55, frame_err=1;
//     next good frame 0x3C -> frame_err=0.
//  4. Back-to-back 0x00 then 0xFF, no idle gap -> two done pulses 10 bit-times apart,
//     values 8'h00 then 8'hFF.
//  5. Assert reset_n during the 4th data bit of 0xA5 -> outputs 0, no pulse. Release, then
//     send 0xA5 -> data_out=8'hA5.
//  6. Loopback: uart_tx (tx_start with data_in=8'hCB) -> uart_rx.rx -> data_out=8'hCB
//     and frame_err=0 for every transmitted word.

Source files
------------

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module      : uart_rx
// Description : Oversampling UART receiver. It checks the start bit, shifts in
//               data LSB-first, checks the stop bit, and pulses rx_done_tick.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
   parameter int DATA_SIZE      = 8,
   parameter int SAMPLE         = 16,
   parameter int STOP_TICKS     = 16,
   parameter int S_CNT_SIZE     = $clog2(STOP_TICKS),
   parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 s_tick,
   input  logic                 rx,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 rx_done_tick,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam logic [S_CNT_SIZE-1:0]     c_half_last = S_CNT_SIZE'(SAMPLE / 2 - 1);
   localparam logic [S_CNT_SIZE-1:0]     c_bit_last  = S_CNT_SIZE'(SAMPLE - 1);
   localparam logic [S_CNT_SIZE-1:0]     c_stop_last = S_CNT_SIZE'(STOP_TICKS - 1);
   localparam logic [BIT_COUNT_SIZE-1:0] c_n_last    = BIT_COUNT_SIZE'(DATA_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                    r_state;
   logic [S_CNT_SIZE-1:0]     r_s_cnt;
   logic [BIT_COUNT_SIZE-1:0] r_n;
   logic [DATA_SIZE-1:0]      r_shreg;
   logic                      r_rx_meta;
   logic                      r_rx_s;

   // The synchronizer resets to the idle-line level so that reset release
   // cannot be mistaken for a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_s_cnt      <= '0;
         r_n          <= '0;
         r_shreg      <= '0;
         data_out     <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!r_rx_s) begin
                  r_state <= START;
                  r_s_cnt <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (r_s_cnt == c_half_last) begin
                     if (!r_rx_s) begin
                        r_state <= DATA;
                        r_s_cnt <= '0;
                        r_n     <= '0;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (r_s_cnt == c_bit_last) begin
                     r_shreg <= {r_rx_s, r_shreg[DATA_SIZE-1:1]};
                     r_s_cnt <= '0;
                     if (r_n == c_n_last) begin
                        r_state <= STOP;
                     end else begin
                        r_n <= r_n + 1'b1;
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (r_s_cnt == c_stop_last) begin
                     // Framing errors still get a done pulse. The consumer
                     // uses frame_err to decide whether to keep the word.
                     data_out     <= r_shreg;
                     frame_err    <= ~r_rx_s;
                     rx_done_tick <= 1'b1;
                     r_state      <= IDLE;
                  end else begin
                     r_s_cnt <= r_s_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with a behavioural line driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

   localparam int c_tick_div = 4;
   localparam int c_bit_clk  = 16 * c_tick_div;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       s_tick;
   logic       rx;
   logic [7:0] data_out;
   logic       rx_done_tick;
   logic       frame_err;
   logic       rx_busy;

   int         r_div = 0;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] pd[$];
   logic       pe[$];
   int         pt[$];

   uart_rx dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_tick       (s_tick),
      .rx           (rx),
      .data_out     (data_out),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      r_div <= (r_div == c_tick_div - 1) ? 0 : r_div + 1;
   end
   assign s_tick = (r_div == c_tick_div - 1);

   always @(negedge clk) begin
      if (rx_done_tick) begin
         pd.push_back(data_out);
         pe.push_back(frame_err);
         pt.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (c_bit_clk) @(negedge clk);
   endtask

   // A low stop bit is held only until the done pulse. This keeps the
   // restart that follows deterministic: it is always a false start.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      int n0;
      int k;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (stop) begin
         send_bit(1'b1);
      end else begin
         n0 = pd.size();
         rx = 1'b0;
         for (k = 0; k < 2 * c_bit_clk && pd.size() == n0; k++) @(negedge clk);
         if (pd.size() == n0) check("stop_pulse_timeout", 0, 1);
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 4 * c_bit_clk && rx_busy; k++) @(negedge clk);
      check("idle_timeout", {31'd0, rx_busy}, 0);
   endtask

   initial begin
      int n0;
      reset_n = 1'b0;
      rx      = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_data", {24'd0, data_out}, 0);
      check("rst_done", {31'd0, rx_done_tick}, 0);
      check("rst_ferr", {31'd0, frame_err}, 0);
      check("rst_busy", {31'd0, rx_busy}, 0);
      reset_n = 1'b1;
      repeat (2 * c_bit_clk) @(negedge clk);

      // 1: single good frame
      send_frame(8'hCB, 1'b1);
      wait_idle();
      check("t1_count", pd.size(), 1);
      if (pd.size() >= 1) begin
         check("t1_data", {24'd0, pd[0]}, 32'hCB);
         check("t1_ferr", {31'd0, pe[0]}, 0);
      end
      check("t1_busy", {31'd0, rx_busy}, 0);

      // 2: glitch shorter than half a bit
      n0 = pd.size();
      rx = 1'b0;
      repeat (4 * c_tick_div) @(negedge clk);
      rx = 1'b1;
      repeat (6 * c_tick_div) @(negedge clk);
      check("t2_busy", {31'd0, rx_busy}, 0);
      repeat (12 * c_bit_clk) @(negedge clk);
      check("t2_count", pd.size(), n0);
      check("t2_data", {24'd0, data_out}, 32'hCB);

      // 3: framing error, then recovery
      n0 = pd.size();
      send_frame(8'h55, 1'b0);
      wait_idle();
      repeat (c_bit_clk) @(negedge clk);
      check("t3_count", pd.size(), n0 + 1);
      check("t3_data", {24'd0, data_out}, 32'h55);
      check("t3_ferr", {31'd0, frame_err}, 1);
      send_frame(8'h3C, 1'b1);
      wait_idle();
      check("t3b_count", pd.size(), n0 + 2);
      check("t3b_data", {24'd0, data_out}, 32'h3C);
      check("t3b_ferr", {31'd0, frame_err}, 0);

      // 4: back-to-back frames with no idle gap
      repeat (c_bit_clk) @(negedge clk);
      n0 = pd.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_idle();
      check("t4_count", pd.size(), n0 + 2);
      if (pd.size() >= n0 + 2) begin
         check("t4_d0", {24'd0, pd[n0]}, 32'h00);
         check("t4_d1", {24'd0, pd[n0+1]}, 32'hFF);
         check("t4_e1", {31'd0, pe[n0+1]}, 0);
         check("t4_gap", pt[n0+1] - pt[n0], 10 * c_bit_clk);
      end

      // 5: reset in the middle of the 4th data bit of 0xA5
      repeat (c_bit_clk) @(negedge clk);
      n0 = pd.size();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b0;
      repeat (c_bit_clk / 2) @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_data", {24'd0, data_out}, 0);
      check("t5_ferr", {31'd0, frame_err}, 0);
      check("t5_busy", {31'd0, rx_busy}, 0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (12 * c_bit_clk) @(negedge clk);
      check("t5_count", pd.size(), n0);
      send_frame(8'hA5, 1'b1);
      wait_idle();
      check("t5b_data", {24'd0, data_out}, 32'hA5);
      check("t5b_count", pd.size(), n0 + 1);

      // 6: a stream of the same word from a transmitter model
      repeat (c_bit_clk) @(negedge clk);
      n0 = pd.size();
      for (int i = 0; i < 3; i++) send_frame(8'hCB, 1'b1);
      wait_idle();
      check("t6_count", pd.size(), n0 + 3);
      for (int i = 0; i < 3; i++) begin
         if (pd.size() > n0 + i) begin
            check("t6_data", {24'd0, pd[n0+i]}, 32'hCB);
            check("t6_ferr", {31'd0, pe[n0+i]}, 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
